// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO and its read-side stream engine.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // Occupancy of the 2-entry output buffer, 0..2.
    typedef logic [1:0] occ_t;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

    // A new read is allowed only while buffered + in-flight words, after this
    // cycle's pop, still leave a free slot.
    function automatic logic has_credit(occ_t occ, logic inflight, logic pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'd2;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream seen by fifo_stream_reader.
interface fifo_stream_reader_if import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic                  flush;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    occ_t                  level;

    modport master (
        input  fifo_dout, fifo_empty, flush, out_ready,
        output fifo_read, out_data, out_valid, level
    );

    modport slave (
        output fifo_dout, fifo_empty, flush, out_ready,
        input  fifo_read, out_data, out_valid, level
    );
endinterface

// File: rtl/stream_buf2.sv
// Two-entry circular buffer: push at tail, pop at head, head word always visible.
module stream_buf2 import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    occ_t                  occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            head_d = 1'b0;
            tail_d = 1'b0;
            occ_d  = '0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            occ_d = occ_q + occ_t'(push) - occ_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (push && !clear) mem_q[tail_q] <= push_data;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO and re-presents its words on a valid/ready stream,
// using a 2-entry buffer and read credits to sustain one word per cycle.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    fifo_stream_reader_if.master bus
);
    occ_t occ;
    logic inflight_q, inflight_d;
    logic pop;
    logic capture;
    logic rd;

    // out_ready feeds rd combinationally so a pop frees a credit in the same cycle.
    always_comb begin
        pop        = bus.out_valid & bus.out_ready;
        rd         = !bus.fifo_empty && !bus.flush && has_credit(occ, inflight_q, pop);
        capture    = inflight_q & !bus.flush;
        inflight_d = rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .push      (capture),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (bus.out_data)
    );

    assign bus.fifo_read = rd;
    assign bus.out_valid = (occ != '0);
    assign bus.level     = occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: behavioural FIFO, word scoreboard and protocol monitors.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int unsigned DW = DEFAULT_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural FIFO: array + pointers, data registered one cycle after a read.
    logic [DW-1:0] fmem [0:1023];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr;
    logic          rd_s = 1'b0;
    logic          rd_prev;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= 0;
            rd_prev       <= 1'b0;
            bus.fifo_dout <= '0;
        end else begin
            rd_prev <= rd_s;
            if (rd_s) begin
                bus.fifo_dout <= fmem[rd_ptr[9:0]];
                rd_ptr        <= rd_ptr + 1;
            end
        end
    end

    // Monitor: collects delivered words and counts protocol violations.
    logic [DW-1:0] got [0:1023];
    int            got_n = 0;
    int            n_ovf = 0;
    int            n_rd_empty = 0;
    int            n_stream = 0;
    int            max_level = 0;
    logic          prev_stall = 1'b0;
    logic          prev_flush = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            rd_s       = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            rd_s = bus.fifo_read;
            if (bus.out_valid && bus.out_ready) begin
                got[got_n[9:0]] = bus.out_data;
                got_n++;
            end
            if (bus.fifo_read && bus.fifo_empty) n_rd_empty++;
            if (rd_prev && !bus.flush && bus.level == 2'd2 && !(bus.out_valid && bus.out_ready))
                n_ovf++;
            if (prev_stall && !prev_flush && (!bus.out_valid || bus.out_data !== prev_data))
                n_stream++;
            if (int'(bus.level) > max_level) max_level = int'(bus.level);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_flush = bus.flush;
            prev_data  = bus.out_data;
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fmem[wr_ptr[9:0]] = d;
        wr_ptr++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (bus.fifo_read !== 1'b0) begin
            fails++; $display("FAIL reset_fifo_read got %b want 0", bus.fifo_read);
        end
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        tests++;
        if (bus.out_data !== '0) begin
            fails++; $display("FAIL reset_out_data got %h want 00", bus.out_data);
        end
        tests++;
        if (bus.level !== 2'd0) begin
            fails++; $display("FAIL reset_level got %0d want 0", bus.level);
        end
        drive_slot();
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        logic          exp_rd, exp_v;
        logic [DW-1:0] exp_d;
        drive_slot();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_rd = (c < 8);
            exp_v  = (c >= 2) && (c < 10);
            exp_d  = DW'(c - 1);
            tests++;
            if (bus.fifo_read !== exp_rd) begin
                fails++;
                $display("FAIL stream_read cycle %0d got %b want %b", c, bus.fifo_read, exp_rd);
            end
            tests++;
            if (bus.out_valid !== exp_v) begin
                fails++;
                $display("FAIL stream_valid cycle %0d got %b want %b", c, bus.out_valid, exp_v);
            end
            if (exp_v) begin
                tests++;
                if (bus.out_data !== exp_d) begin
                    fails++;
                    $display("FAIL stream_data cycle %0d got %h want %h", c, bus.out_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nread = 0;
        int start;
        drive_slot();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'(8'h10 + i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.fifo_read) nread++;
        end
        tests++;
        if (nread !== 2) begin
            fails++; $display("FAIL bp_reads got %0d want 2", nread);
        end
        tests++;
        if (bus.level !== 2'd2) begin
            fails++; $display("FAIL bp_level got %0d want 2", bus.level);
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(8'h10)) begin
            fails++;
            $display("FAIL bp_head got v=%b d=%h want v=1 d=10", bus.out_valid, bus.out_data);
        end
        drive_slot();
        start = got_n;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && (got_n - start) < 6; c++) drive_slot();
        repeat (3) drive_slot();
        tests++;
        if (got_n - start !== 6) begin
            fails++; $display("FAIL bp_count got %0d want 6", got_n - start);
        end
        for (int i = 0; i < 6 && i < got_n - start; i++) begin
            tests++;
            if (got[(start + i) % 1024] !== DW'(8'h10 + i)) begin
                fails++;
                $display("FAIL bp_order idx %0d got %h want %h", i, got[(start + i) % 1024],
                         DW'(8'h10 + i));
            end
        end
    endtask

    task automatic test_alternating();
        logic [DW-1:0] exp [8];
        int start, ovf0, str0;
        drive_slot();
        start = got_n;
        ovf0  = n_ovf;
        str0  = n_stream;
        for (int i = 0; i < 8; i++) begin
            exp[i] = DW'($urandom);
            push_word(exp[i]);
        end
        for (int c = 0; c < 60 && (got_n - start) < 8; c++) begin
            bus.out_ready = (c % 2 == 0);
            drive_slot();
        end
        bus.out_ready = 1'b1;
        repeat (4) drive_slot();
        tests++;
        if (got_n - start !== 8) begin
            fails++; $display("FAIL alt_count got %0d want 8", got_n - start);
        end
        for (int i = 0; i < 8 && i < got_n - start; i++) begin
            tests++;
            if (got[(start + i) % 1024] !== exp[i]) begin
                fails++;
                $display("FAIL alt_order idx %0d got %h want %h", i, got[(start + i) % 1024],
                         exp[i]);
            end
        end
        tests++;
        if (n_ovf - ovf0 !== 0 || max_level > 2) begin
            fails++;
            $display("FAIL alt_overflow got ovf=%0d maxlvl=%0d want 0/<=2", n_ovf - ovf0,
                     max_level);
        end
        tests++;
        if (n_stream - str0 !== 0) begin
            fails++; $display("FAIL alt_stream_rule got %0d want 0", n_stream - str0);
        end
    endtask

    task automatic test_empty();
        int nr = 0, nv = 0;
        logic [DW-1:0] vd = '0;
        drive_slot();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.fifo_read) nr++;
            if (bus.out_valid) nv++;
        end
        tests++;
        if (nr !== 0 || nv !== 0) begin
            fails++; $display("FAIL empty_idle got reads=%0d valids=%0d want 0/0", nr, nv);
        end
        drive_slot();
        push_word(DW'(8'hA5));
        nr = 0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.fifo_read) nr++;
            if (bus.out_valid) begin
                nv++;
                vd = bus.out_data;
            end
        end
        tests++;
        if (nr !== 1 || nv !== 1) begin
            fails++; $display("FAIL empty_single got reads=%0d beats=%0d want 1/1", nr, nv);
        end
        tests++;
        if (vd !== DW'(8'hA5)) begin
            fails++; $display("FAIL empty_data got %h want a5", vd);
        end
    endtask

    task automatic test_flush();
        int start;
        drive_slot();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(8'h20 + i));
        @(negedge clk);
        @(negedge clk);
        // Second read (0x21) is in flight as flush is pulsed.
        drive_slot();
        bus.flush = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.level !== 2'd1 || bus.fifo_read !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle got lvl=%0d rd=%b want 1/0", bus.level, bus.fifo_read);
        end
        drive_slot();
        bus.flush = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.level !== 2'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_after got lvl=%0d v=%b want 0/0", bus.level, bus.out_valid);
        end
        drive_slot();
        start = got_n;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (got_n - start) < 2; c++) drive_slot();
        repeat (4) drive_slot();
        tests++;
        if (got_n - start !== 2) begin
            fails++; $display("FAIL flush_count got %0d want 2", got_n - start);
        end
        for (int i = 0; i < 2 && i < got_n - start; i++) begin
            tests++;
            if (got[(start + i) % 1024] !== DW'(8'h22 + i)) begin
                fails++;
                $display("FAIL flush_next idx %0d got %h want %h", i, got[(start + i) % 1024],
                         DW'(8'h22 + i));
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp [80];
        int wi = 0;
        int start;
        int errs = 0;
        drive_slot();
        start = got_n;
        for (int c = 0; c < 2000 && !((got_n - start) >= 80 && wi == 80); c++) begin
            if (wi < 80 && $urandom_range(0, 3) != 0) begin
                exp[wi] = DW'($urandom);
                push_word(exp[wi]);
                wi++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive_slot();
        end
        bus.out_ready = 1'b1;
        repeat (4) drive_slot();
        tests++;
        if (got_n - start !== 80) begin
            fails++; $display("FAIL rand_count got %0d want 80", got_n - start);
        end
        for (int i = 0; i < 80 && i < got_n - start; i++) begin
            if (got[(start + i) % 1024] !== exp[i]) errs++;
        end
        tests++;
        if (errs !== 0) begin
            fails++; $display("FAIL rand_order got %0d wrong words want 0", errs);
        end
    endtask

    task automatic test_async_reset();
        int start;
        drive_slot();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
        repeat (4) @(posedge clk);
        #3;
        rst    = 1'b0;
        wr_ptr = 0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.fifo_read !== 1'b0 || bus.level !== 2'd0) begin
            fails++;
            $display("FAIL async_reset got v=%b rd=%b lvl=%0d want 0/0/0", bus.out_valid,
                     bus.fifo_read, bus.level);
        end
        @(negedge clk);
        drive_slot();
        rst = 1'b1;
        start = got_n;
        for (int i = 0; i < 4; i++) push_word(DW'(8'h40 + i));
        for (int c = 0; c < 30 && (got_n - start) < 4; c++) drive_slot();
        repeat (4) drive_slot();
        tests++;
        if (got_n - start !== 4) begin
            fails++; $display("FAIL reset_resume_count got %0d want 4", got_n - start);
        end
        for (int i = 0; i < 4 && i < got_n - start; i++) begin
            tests++;
            if (got[(start + i) % 1024] !== DW'(8'h40 + i)) begin
                fails++;
                $display("FAIL reset_resume idx %0d got %h want %h", i, got[(start + i) % 1024],
                         DW'(8'h40 + i));
            end
        end
    endtask

    task automatic test_protocol_monitors();
        tests++;
        if (n_ovf !== 0) begin
            fails++; $display("FAIL overflow got %0d events want 0", n_ovf);
        end
        tests++;
        if (n_rd_empty !== 0) begin
            fails++; $display("FAIL read_while_empty got %0d events want 0", n_rd_empty);
        end
        tests++;
        if (n_stream !== 0) begin
            fails++; $display("FAIL stream_hold got %0d events want 0", n_stream);
        end
        tests++;
        if (max_level > 2) begin
            fails++; $display("FAIL max_level got %0d want <=2", max_level);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_empty();
        test_flush();
        test_random();
        test_async_reset();
        test_protocol_monitors();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
